// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared FSM states, NOP constant and queue entry layout
package fetch_queue_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DROP, HALT} state_t;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef struct packed {
    logic        err;
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry queue of fetched instructions with flush
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  entry_t        din,
  output logic [AW:0]   count,
  output entry_t        head
);
  entry_t mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  // pointers carry an extra wrap bit so full and empty differ; flush wins
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  // storage write at the tail
  always_ff @(posedge clk_i)
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  assign count = wr_ptr - rd_ptr;
  assign head = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: prefetching Wishbone fetch front end feeding decode via valid/ready
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h8000_0000,
  parameter int DEPTH = 4,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             redirect_i,
  input  logic [31:0]      redirect_addr_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_instr_o,
  output logic [31:0]      out_pc_o,
  output logic             out_err_o,
  output logic [LVL_W-1:0] level_o,
  input  logic [31:0]      wbm_dat_i,
  input  logic             wbm_ack_i,
  input  logic             wbm_err_i,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic [31:0]      wbm_addr_o
);
  state_t state, state_n;
  logic [31:0] fetch_pc, pc_n, addr_n;
  logic cyc_n, resp, push, pop;
  logic [LVL_W-1:0] count;
  entry_t head;
  int lvl;
  assign resp = wbm_ack_i | wbm_err_i;
  assign pop = out_valid_o & out_ready_i & ~redirect_i;
  assign push = (state == BUSY) & resp & ~redirect_i;
  assign lvl = int'(count) - (pop ? 1 : 0);
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .flush (redirect_i),
    .push  (push),
    .pop   (pop),
    .din   ('{err: wbm_err_i, pc: wbm_addr_o, instr: wbm_dat_i}),
    .count (count),
    .head  (head)
  );
  assign out_valid_o = count != '0;
  assign out_instr_o = out_valid_o ? head.instr : NOP;
  assign out_pc_o = out_valid_o ? head.pc : 32'h0;
  assign out_err_o = out_valid_o & head.err;
  assign level_o = count;
  assign wbm_stb_o = wbm_cyc_o;
  // next state: a request is only opened when a slot is guaranteed for its response
  always_comb begin
    state_n = state;
    cyc_n = wbm_cyc_o;
    addr_n = wbm_addr_o;
    pc_n = fetch_pc;
    if (redirect_i) begin
      pc_n = redirect_addr_i & ~32'h3;
      cyc_n = wbm_cyc_o & ~resp;
      state_n = cyc_n ? DROP : IDLE;
    end else if (state == IDLE && lvl < DEPTH) begin
      state_n = BUSY;
      cyc_n = 1'b1;
      addr_n = fetch_pc;
    end else if (state == BUSY && wbm_err_i) begin
      state_n = HALT;
      cyc_n = 1'b0;
    end else if (state == BUSY && wbm_ack_i) begin
      pc_n = fetch_pc + 32'd4;
      addr_n = fetch_pc + 32'd4;
      cyc_n = lvl + 1 < DEPTH;
      state_n = cyc_n ? BUSY : IDLE;
    end else if (state == DROP && resp) begin
      state_n = IDLE;
      cyc_n = 1'b0;
    end
  end
  // registered FSM, fetch pointer and bus signals
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state <= IDLE;
      wbm_cyc_o <= 1'b0;
      wbm_addr_o <= RESET_ADDR;
      fetch_pc <= RESET_ADDR;
    end else begin
      state <= state_n;
      wbm_cyc_o <= cyc_n;
      wbm_addr_o <= addr_n;
      fetch_pc <= pc_n;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupled instruction-fetch front end: Wishbone classic master that prefetches sequential instructions into a parametrised-depth queue.
- Supplies the IF/ID boundary through a valid/ready handshake.
- Supports redirect (branch/jump/exception) with flush of queued and in-flight fetches, and bus-error tagging.
- Replaces the single-entry fetch path; decode stalls by deasserting ready instead of holding the fetch bus.

Parameters:
- RESET_ADDR, 32'h8000_0000, first fetch address after reset.
- DEPTH, 4, queue entries; power of two, >= 2.
- LVL_W, $clog2(DEPTH+1), derived width of level_o; not overridden.

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- redirect_i  in  1  flush queue and restart fetch at redirect_addr_i.
- redirect_addr_i  in  32  new fetch address; bits [1:0] ignored (forced 0).
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  consumer accepts head this cycle.
- out_instr_o  out  32  head instruction.
- out_pc_o  out  32  head PC.
- out_err_o  out  1  head entry came from a bus error.
- level_o  out  LVL_W  entries currently queued.
- wbm_dat_i  in  32  read data.
- wbm_ack_i  in  1  cycle ack.
- wbm_err_i  in  1  cycle error.
- wbm_cyc_o  out  1  bus cycle.
- wbm_stb_o  out  1  strobe (always equals wbm_cyc_o).
- wbm_addr_o  out  32  fetch address.

Behaviour:
- Reset (rst_i low, async):
  - wbm_cyc_o/stb_o = 0, wbm_addr_o = RESET_ADDR, fetch_pc = RESET_ADDR.
  - Queue empty: out_valid_o = 0, level_o = 0, out_err_o = 0.
  - out_instr_o = 32'h0000_0013 (NOP), out_pc_o = 0.
  - State IDLE.
- Head outputs: whenever the queue is empty, out_instr_o is the NOP value and out_pc_o is 0. All outputs are registered or driven from queue storage; no combinational path from wbm_* to out_*.
- Pop: out_valid_o && out_ready_i removes the head at the clock edge.
- Push: a non-discarded ack or err writes {err, pc, data} at the tail.
  - A push on ack/err in cycle N is visible at out_* in cycle N+1.
  - Simultaneous push and pop keeps level_o unchanged.
- Slot reservation: a request is issued only when level_o (after this edge's pop) < DEPTH, so a push never finds the queue full.
- FSM states:
  - IDLE: if not redirect and a slot is free, next cycle cyc=stb=1 with addr=fetch_pc, go BUSY.
  - BUSY: hold cyc/stb/addr until ack or err.
    - On ack: push, fetch_pc += 4. If a slot remains after this edge, stay BUSY with stb held high and addr = new fetch_pc (back-to-back, one fetch per cycle at zero wait states). Otherwise drop cyc/stb and go IDLE.
    - On err: push with err = 1, drop cyc/stb, go HALT.
  - DROP: redirect arrived while a cycle was open. Hold cyc/stb/addr until ack or err, discard the response, drop cyc/stb, go IDLE.
  - HALT: no fetching; the queue drains normally; only redirect leaves (to IDLE).
- Redirect (any state), at the edge:
  - Queue flushed: level_o = 0 and out_valid_o = 0 the next cycle; a same-cycle pop is ignored.
  - fetch_pc = {redirect_addr_i[31:2], 2'b00}.
  - BUSY without ack/err -> DROP. BUSY with ack/err in the same cycle -> response discarded, -> IDLE.
  - DROP -> DROP with the address updated; a same-cycle ack/err in DROP -> IDLE.
  - IDLE/HALT -> IDLE.
- First post-redirect request is asserted no earlier than the cycle after the redirect edge.
- fetch_pc wraps modulo 2^32 (0xFFFF_FFFC + 4 = 0).
- Reset mid-cycle: cyc/stb drop immediately and asynchronously; all state returns to reset values.

Decomposition:
- Shared defines file: FSM state encodings (IDLE, BUSY, DROP, HALT), NOP constant 32'h0000_0013, queue entry field layout {err, pc, instr} = 65 bits.
- One sub-module: fetch_fifo.
  - Synchronous DEPTH x 65 FIFO with push, pop and flush (flush has priority over pop and push).
  - Outputs count and head.
  - Pointers one bit wider than log2(DEPTH) to distinguish full from empty.
- fetch_queue holds the FSM, fetch_pc and the Wishbone signals.

Test Plan:
- Reset release, ack one cycle after each stb, out_ready_i = 1:
  - wbm_addr_o sequence 0x8000_0000, 0x8000_0004, 0x8000_0008.
  - Each out_pc_o matches its address one cycle after its ack; out_err_o = 0.
- DEPTH = 4, out_ready_i = 0, zero-wait acks:
  - Exactly 4 acks, then cyc low, level_o = 4.
  - Raise ready for 1 cycle -> one pop, one new fetch at 0x8000_0010.
- Redirect to 0x0000_0102 while BUSY with ack delayed 3 cycles:
  - Queue empties next cycle and the acked data is discarded.
  - Next request addr = 0x0000_0100; first output pc = 0x0000_0100.
- Redirect and ack in the same cycle: no push, FSM IDLE, next request at the redirect address.
- wbm_err_i on fetch of 0x8000_0008:
  - Entry with out_err_o = 1, pc 0x8000_0008; no further cyc.
  - Redirect to 0x8000_0100 -> fetch resumes there.
- fetch_pc at 0xFFFF_FFFC, ack: next address 0x0000_0000.
- rst_i low mid-BUSY: cyc/stb fall without a clock edge; after release, first fetch at RESET_ADDR.
